// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and default geometry.
package serial_pattern_pkg;

  localparam int MAX_LEN_DEFAULT = 8;
  localparam int LEN_W_DEFAULT   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Job request / serial output bundle for serial_pattern_tx.
// Handshake: start is a request that is taken only while the block is idle
// (busy=0, no done pulse showing); there is no ready, and a start seen while
// busy is dropped, so the master re-asserts start until busy goes high or
// err pulses.
interface serial_pattern_tx_if
  import serial_pattern_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int LEN_W   = LEN_W_DEFAULT
);

  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   reps;
  logic               abort;
  logic               out;
  logic               out_valid;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, pattern, len, reps, abort,
    input  out, out_valid, busy, done, err
  );

  modport slave (
    input  start, pattern, len, reps, abort,
    output out, out_valid, busy, done, err
  );

endinterface

// File: rtl/pattern_shreg.sv
// Frame store plus working shift register. The working copy is kept one bit
// ahead of the bit currently on the line, so its MSB is always the next bit.
module pattern_shreg
  import serial_pattern_pkg::*;
#(
  parameter int W = MAX_LEN_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         reload,
  input  logic [W-1:0] d,
  output logic         work_msb,
  output logic         frame_msb
);

  logic [W-1:0] frame_q;
  logic [W-1:0] work_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      work_q  <= '0;
    end else if (load) begin
      frame_q <= d;
      work_q  <= d << 1;
    end else if (reload) begin
      work_q  <= frame_q << 1;
    end else if (shift) begin
      work_q  <= work_q << 1;
    end
  end

  assign work_msb  = work_q[W-1];
  assign frame_msb = frame_q[W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a captured len-bit frame MSB-first,
// reps+1 times back to back, then pulses done. Moore FSM, registered outputs.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int LEN_W   = LEN_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  serial_pattern_tx_if.slave  bus,
  output state_t              dbg_state
);

  localparam logic [LEN_W:0] MAX_LEN_V = (LEN_W+1)'(MAX_LEN);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [LEN_W-1:0] len_m1_q, len_m1_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic               sr_load, sr_shift, sr_reload;
  logic               work_msb, frame_msb;
  logic               len_ok;
  logic [LEN_W:0]     shamt;
  logic [MAX_LEN-1:0] aligned;

  // Left-align the frame so its first bit always sits at the register MSB.
  assign len_ok  = (bus.len != '0) && ({1'b0, bus.len} <= MAX_LEN_V);
  assign shamt   = MAX_LEN_V - {1'b0, bus.len};
  assign aligned = bus.pattern << shamt;

  pattern_shreg #(.W(MAX_LEN)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .shift     (sr_shift),
    .reload    (sr_reload),
    .d         (aligned),
    .work_msb  (work_msb),
    .frame_msb (frame_msb)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    len_m1_d    = len_m1_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_reload   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (len_ok) begin
            state_d     = SHIFT;
            sr_load     = 1'b1;
            len_m1_d    = bus.len - LEN_W'(1);
            bit_cnt_d   = bus.len - LEN_W'(1);
            rep_cnt_d   = bus.reps;
            out_d       = aligned[MAX_LEN-1];
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        // bit_cnt counts bits still to send in this frame after the one on the line
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bit_cnt_q != '0) begin
          sr_shift    = 1'b1;
          bit_cnt_d   = bit_cnt_q - LEN_W'(1);
          out_d       = work_msb;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else if (rep_cnt_q != '0) begin
          sr_reload   = 1'b1;
          bit_cnt_d   = len_m1_q;
          rep_cnt_d   = rep_cnt_q - LEN_W'(1);
          out_d       = frame_msb;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      len_m1_q    <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      len_m1_q    <= len_m1_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: a job-level model expands each
// request into the per-cycle output words the block must show.
module tb_serial_pattern_tx;
  import serial_pattern_pkg::*;

  localparam int ML = 8;
  localparam int LW = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  serial_pattern_tx_if #(.MAX_LEN(ML), .LEN_W(LW)) bus ();

  serial_pattern_tx #(.MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // word layout: {busy, out_valid, out, done, err}
  logic [4:0] exp_q[$];
  logic [4:0] mdl_q[$];
  int         n_vec     = 0;
  int         n_err     = 0;
  int         valid_cnt = 0;
  bit         cmp_en    = 1'b0;

  function automatic logic [4:0] obs();
    return {bus.busy, bus.out_valid, bus.out, bus.done, bus.err};
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Job model: every frame bit from pattern[len-1] down to pattern[0],
  // repeated reps+1 times, then one done cycle with busy still high.
  function automatic void model_job(logic [ML-1:0] p, int l, int r);
    mdl_q.delete();
    for (int k = 0; k <= r; k++)
      for (int i = l - 1; i >= 0; i--)
        mdl_q.push_back({1'b1, 1'b1, p[i], 1'b0, 1'b0});
    mdl_q.push_back(5'b10010);
  endfunction

  function automatic void push_job(logic [ML-1:0] p, int l, int r);
    model_job(p, l, r);
    foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
  endfunction

  function automatic logic [31:0] model_bits();
    logic [31:0] s;
    s = '0;
    foreach (mdl_q[i]) if (mdl_q[i][3]) s = {s[30:0], mdl_q[i][2]};
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [4:0] e;
    if (cmp_en) begin
      e = 5'b00000;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check("cycle", 32'(obs()), 32'(e));
      if (bus.out_valid) valid_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
  endtask

  task automatic run_job(logic [ML-1:0] p, int l, int r);
    int base;
    bus.start   = 1'b1;
    bus.pattern = p;
    bus.len     = LW'(l);
    bus.reps    = LW'(r);
    tick();
    bus.start = 1'b0;
    base = valid_cnt;
    push_job(p, l, r);
    bus.pattern = ~p;
    bus.len     = LW'(15);
    bus.reps    = LW'(7);
    wait_drain();
    check("valid_count", valid_cnt - base, l * (r + 1));
  endtask

  task automatic err_job(int l);
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    bus.len     = LW'(l);
    bus.reps    = '0;
    tick();
    bus.start = 1'b0;
    exp_q.push_back(5'b00001);
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.reps    = '0;
    bus.abort   = 1'b0;

    // pin the model against hand-derived sequences
    model_job(8'h03, 3, 0);
    check("pin_011_bits", model_bits(), 32'h3);
    check("pin_011_len", mdl_q.size(), 4);
    model_job(8'hA5, 8, 0);
    check("pin_a5_bits", model_bits(), 32'hA5);
    model_job(8'hF6, 4, 0);
    check("pin_f6_low_nibble", model_bits(), 32'h6);
    model_job(8'h02, 2, 15);
    check("pin_max_reps_len", mdl_q.size(), 33);
    check("pin_max_reps_bits", model_bits(), 32'hAAAAAAAA);

    // asynchronous reset before any clock edge
    #1 rst = 1'b0;
    #1;
    check("reset_outputs", 32'(obs()), 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    cmp_en = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;

    // first start right after release, pattern 011 len 3
    run_job(8'h03, 3, 0);
    // 2'b11 repeated three times, no gaps
    run_job(8'h03, 2, 2);
    // illegal lengths: 0, MAX_LEN+1, largest code
    err_job(0);
    err_job(ML + 1);
    err_job(15);
    // boundaries: len=1, len=MAX_LEN, high bits beyond len ignored, max reps
    run_job(8'h01, 1, 0);
    run_job(8'hA5, 8, 0);
    run_job(8'hF6, 4, 0);
    run_job(8'h02, 2, 15);

    // abort on 4th valid cycle of A5: 1,0,1,0 then idle, no done
    bus.start = 1'b1; bus.pattern = 8'hA5; bus.len = LW'(8); bus.reps = '0;
    tick();
    bus.start = 1'b0;
    model_job(8'hA5, 8, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(mdl_q[i]);
    tick();
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_drain();
    tick();

    // abort together with start in IDLE: nothing accepted, no err
    bus.start = 1'b1; bus.abort = 1'b1; bus.pattern = 8'h07; bus.len = LW'(3);
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    tick();
    tick();

    // abort during the done cycle has no effect
    bus.start = 1'b1; bus.pattern = 8'h01; bus.len = LW'(1); bus.reps = '0;
    tick();
    bus.start = 1'b0;
    push_job(8'h01, 1, 0);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    wait_drain();

    // start pulse while busy is ignored
    bus.start = 1'b1; bus.pattern = 8'h09; bus.len = LW'(4); bus.reps = LW'(1);
    tick();
    bus.start = 1'b0;
    push_job(8'h09, 4, 1);
    tick();
    tick();
    bus.start = 1'b1; bus.pattern = 8'hFF; bus.len = LW'(2); bus.reps = '0;
    tick();
    bus.start = 1'b0;
    wait_drain();

    // start held high with a changing pattern: second job only after IDLE
    bus.start = 1'b1; bus.pattern = 8'h06; bus.len = LW'(3); bus.reps = '0;
    tick();
    push_job(8'h06, 3, 0);
    exp_q.push_back(5'b00000);
    push_job(8'h02, 3, 0);
    bus.pattern = 8'h01; bus.reps = LW'(5);
    tick();
    bus.pattern = 8'h07;
    tick();
    bus.pattern = 8'h02; bus.reps = '0;
    tick();
    tick();
    tick();
    bus.start = 1'b0;
    wait_drain();

    // reset between edges mid-frame, then a full job from its first bit
    bus.start = 1'b1; bus.pattern = 8'hA5; bus.len = LW'(8); bus.reps = '0;
    tick();
    bus.start = 1'b0;
    push_job(8'hA5, 8, 0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("async_rst_outputs", 32'(obs()), 0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b1;
    run_job(8'h3C, 6, 1);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum pattern length in bits.
REQ-002 SHALL have parameter LEN_W, default 4, meaning width of len and reps inputs.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to transmit one job; sampled only in IDLE.
REQ-006 SHALL have port pattern  input  MAX_LEN  bits to send; pattern[len-1] is sent first.
REQ-007 SHALL have port len  input  LEN_W  number of bits per frame, legal range 1..MAX_LEN.
REQ-008 SHALL have port reps  input  LEN_W  extra repetitions; frame is sent reps+1 times.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the job in progress.
REQ-010 SHALL have port out  output  1  serial data bit.
REQ-011 SHALL have port out_valid  output  1  high on every cycle out carries a pattern bit.
REQ-012 SHALL have port busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last bit of the last frame.
REQ-014 SHALL have port err  output  1  one-cycle pulse when start is rejected for illegal len.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, SHIFT and DONE; all outputs registered.
REQ-016 In IDLE, start=1 with 1<=len<=MAX_LEN SHALL capture pattern, len and reps and enter SHIFT next cycle.
REQ-017 In IDLE, start=1 with len=0 or len>MAX_LEN SHALL assert err for one cycle and remain in IDLE.
REQ-018 The first bit SHALL appear on out with out_valid=1 exactly one cycle after the accepting edge.
REQ-019 In SHIFT, each cycle SHALL present the next bit MSB-first (pattern[len-1] down to pattern[0]).
REQ-020 At the end of a frame with remaining reps>0, the next frame SHALL start on the following cycle with no gap, and reps SHALL decrement.
REQ-021 At the end of the last frame, the FSM SHALL enter DONE; done=1, out_valid=0, out=0 for that one cycle, then return to IDLE.
REQ-022 Total out_valid cycles per job SHALL equal len*(reps+1).
REQ-023 start while busy=1 SHALL be ignored, with no effect on the captured job.
REQ-024 abort=1 in SHIFT SHALL return to IDLE next cycle: out_valid=0, busy=0, no done pulse.
REQ-025 abort=1 in IDLE or DONE SHALL have no effect; abort and start together in IDLE SHALL give abort priority (no job accepted).
REQ-026 Input changes to pattern/len/reps after capture SHALL not affect the job in progress.
REQ-027 Bit and repetition counters SHALL never wrap; reps=2^LEN_W-1 SHALL be sent exactly 2^LEN_W times.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE and out=0, out_valid=0, busy=0, done=0, err=0, and clear all internal registers.
REQ-029 Reset asserted mid-job SHALL drop the job; after release the block SHALL idle until a new start.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 State encoding (IDLE, SHIFT, DONE) and the MAX_LEN default SHALL live in shared package serial_pattern_pkg.
REQ-032 A single sub-module pattern_shreg (loadable, MSB-first shift register with reload) SHALL hold frame bits; counters and FSM SHALL stay in the top.

Verification
REQ-033 pattern=3'b011, len=3, reps=0, start one cycle -> out 0,1,1 with out_valid on 3 consecutive cycles, then done pulse, busy low after.
REQ-034 pattern=2'b11, len=2, reps=2 -> out 1,1,1,1,1,1 over 6 gapless valid cycles, single done pulse.
REQ-035 start with len=0, then len=MAX_LEN+1 -> err pulse each time, out_valid stays 0, busy stays 0.
REQ-036 pattern=8'hA5, len=8, abort asserted on 4th valid cycle -> exactly 3 bits 1,0,1 seen plus the abort-cycle bit, out_valid=0 next cycle, no done.
REQ-037 rst=0 asynchronously between edges mid-frame -> all outputs 0 immediately; new start after release sends full frame from first bit.
REQ-038 start held high through a job with changing pattern -> only the captured pattern sent; a second job begins only after return to IDLE.
